// File: rtl/counter_updown_mod_pkg.sv
// Shared constants, next-state action encoding and parameter legality check
// for the up/down modulo-N counter.
package counter_updown_mod_pkg;

   localparam logic UP          = 1'b0;
   localparam logic DOWN        = 1'b1;
   localparam logic LOAD_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_COUNT,
      ACT_LOAD,
      ACT_RESET
   } act_e;

   function automatic bit modulus_ok(int width, int modulus);
      return (width >= 2) && (width <= 16) &&
             (modulus >= 2) && (modulus <= (1 << width));
   endfunction

endpackage

// File: rtl/counter_updown_mod_tc_detect.sv
// Terminal-count detector: TERM is MODULUS-1 counting up and 0 counting down.
module counter_updown_mod_tc_detect
   import counter_updown_mod_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic [WIDTH-1:0] Q,
   input  logic             UD,
   output logic             at_term
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] term;

   assign term    = (UD == UP) ? MAX_Q : '0;
   assign at_term = (Q == term);

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised synchronous up/down modulo-N counter with 161-style EP/ET
// enables, cascadable CO and a sticky overflow flag.
module counter_updown_mod
   import counter_updown_mod_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             LD,
   input  logic             EP,
   input  logic             ET,
   input  logic             UD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             CO,
   output logic             OV
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_param
      $error("counter_updown_mod: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end

   logic             at_term;
   logic [WIDTH-1:0] d_sat;
   act_e             act;

   counter_updown_mod_tc_detect #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tc (
      .Q       (Q),
      .UD      (UD),
      .at_term (at_term)
   );

   // CO stays combinational so a chained stage sees it on the same edge.
   assign CO    = ET & at_term;
   assign d_sat = ({1'b0, D} < MOD_EXT) ? D : MAX_Q;

   always_comb begin
      act = ACT_HOLD;
      if (CR)
         act = ACT_RESET;
      else if (LD == LOAD_ACTIVE)
         act = ACT_LOAD;
      else if (EP & ET)
         act = ACT_COUNT;
   end

   always_ff @(posedge CP) begin
      unique case (act)
         ACT_RESET: begin
            Q  <= '0;
            OV <= 1'b0;
         end
         ACT_LOAD: begin
            Q  <= d_sat;
            OV <= 1'b0;
         end
         ACT_COUNT: begin
            if (at_term) begin
               OV <= 1'b1;
               if (SATURATE == 0)
                  Q <= (UD == DOWN) ? MAX_Q : '0;
            end else begin
               Q <= (UD == DOWN) ? Q - 1'b1 : Q + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: wrap, saturate and MODULUS=16 counters on a shared control
// bus, plus a two-digit decade cascade; expected values go through a queue.
module tb_counter_updown_mod;

   logic       CP = 1'b0;
   logic       cr, ld, ep, et, ud;
   logic [3:0] d;
   logic [3:0] q_w, q_s, q_h;
   logic       co_w, co_s, co_h, ov_w, ov_s, ov_h;

   logic       cr_c, ld_c, ep_c;
   logic [3:0] q_lo, q_hi;
   logic       co_lo, co_hi, ov_lo, ov_hi;

   always #5 CP = ~CP;

   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_w (
      .CP(CP), .CR(cr), .LD(ld), .EP(ep), .ET(et), .UD(ud), .D(d),
      .Q(q_w), .CO(co_w), .OV(ov_w));
   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
      .CP(CP), .CR(cr), .LD(ld), .EP(ep), .ET(et), .UD(ud), .D(d),
      .Q(q_s), .CO(co_s), .OV(ov_s));
   counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_h (
      .CP(CP), .CR(cr), .LD(ld), .EP(ep), .ET(et), .UD(ud), .D(d),
      .Q(q_h), .CO(co_h), .OV(ov_h));

   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
      .CP(CP), .CR(cr_c), .LD(ld_c), .EP(ep_c), .ET(1'b1), .UD(1'b0), .D(4'd0),
      .Q(q_lo), .CO(co_lo), .OV(ov_lo));
   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
      .CP(CP), .CR(cr_c), .LD(ld_c), .EP(ep_c), .ET(co_lo), .UD(1'b0), .D(4'd0),
      .Q(q_hi), .CO(co_hi), .OV(ov_hi));

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [15:0] obs);
      exp_t e;
      n_total++;
      if (sb.size() == 0) begin
         $error("FAIL sb_empty observed=%0d", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   initial begin
      // simultaneous CR and load: reset wins
      cr = 1; ld = 0; d = 4'd9; ep = 1; et = 1; ud = 0;
      cr_c = 1; ld_c = 1; ep_c = 0;
      push("rst_q", 16'd0); push("rst_ov", 16'd0); push("rst_co_up", 16'd0);
      tick();
      pop_chk(16'(q_w)); pop_chk(16'(ov_w)); pop_chk(16'(co_w));
      ud = 1;
      push("rst_co_down", 16'd1);
      #1 pop_chk(16'(co_w));
      ud = 0;

      // load, and clamp of out-of-range data
      cr = 0; ld = 0; d = 4'd9;
      push("load9", 16'd9);
      tick(); pop_chk(16'(q_w));
      d = 4'd12;
      push("load12_clamp", 16'd9); push("load12_m16", 16'd12);
      tick(); pop_chk(16'(q_w)); pop_chk(16'(q_h));

      // up count from 7: wrap vs saturate
      d = 4'd7;
      push("load7_ov", 16'd0);
      tick(); pop_chk(16'(ov_w));
      ld = 1; ep = 1; et = 1; ud = 0;
      push("up1_q", 16'd8); push("up1_co", 16'd0);
      tick(); pop_chk(16'(q_w)); pop_chk(16'(co_w));
      push("up2_q", 16'd9); push("up2_co", 16'd1); push("up2_ov", 16'd0);
      tick(); pop_chk(16'(q_w)); pop_chk(16'(co_w)); pop_chk(16'(ov_w));
      push("up3_q", 16'd0); push("up3_ov", 16'd1); push("up3_sat_q", 16'd9);
      push("up3_sat_ov", 16'd1);
      tick(); pop_chk(16'(q_w)); pop_chk(16'(ov_w)); pop_chk(16'(q_s));
      pop_chk(16'(ov_s));

      // down from 2: saturate holds at 0, wrap goes to 9
      ld = 0; d = 4'd2;
      push("load2_ov_clr", 16'd0);
      tick(); pop_chk(16'(ov_s));
      ld = 1; ud = 1;
      push("dn1_q", 16'd1);
      tick(); pop_chk(16'(q_s));
      push("dn2_q", 16'd0); push("dn2_co", 16'd1); push("dn2_ov", 16'd0);
      tick(); pop_chk(16'(q_s)); pop_chk(16'(co_s)); pop_chk(16'(ov_s));
      push("dn3_q", 16'd0); push("dn3_wrap_q", 16'd9); push("dn3_wrap_ov", 16'd1);
      tick(); pop_chk(16'(q_s)); pop_chk(16'(q_w)); pop_chk(16'(ov_w));
      push("dn4_q", 16'd0); push("dn4_co", 16'd1); push("dn4_ov", 16'd1);
      push("dn4_wrap_q", 16'd8);
      tick(); pop_chk(16'(q_s)); pop_chk(16'(co_s)); pop_chk(16'(ov_s));
      pop_chk(16'(q_w));

      // reversal takes effect on the very next edge
      ud = 0;
      push("rev_q", 16'd9);
      tick(); pop_chk(16'(q_w));

      // enable hold with EP=0
      ld = 0; d = 4'd5;
      tick();
      ld = 1; ep = 0; et = 1;
      for (int i = 0; i < 3; i++) begin
         push("hold_q", 16'd5); push("hold_co", 16'd0);
         tick(); pop_chk(16'(q_w)); pop_chk(16'(co_w));
      end

      // ET=0 gates CO at the terminal and blocks counting
      ld = 0; d = 4'd15;
      tick();
      ld = 1; ep = 1; et = 0;
      push("et0_q", 16'd15); push("et0_co", 16'd0);
      tick(); pop_chk(16'(q_h)); pop_chk(16'(co_h));
      et = 1;
      push("et1_co", 16'd1);
      #1 pop_chk(16'(co_h));

      // mid-count reset after a wrap has set OV
      ld = 0; d = 4'd8;
      tick();
      ld = 1; ep = 1; et = 1; ud = 0;
      for (int i = 0; i < 8; i++) tick();
      push("pre_rst_q", 16'd6); push("pre_rst_ov", 16'd1);
      pop_chk(16'(q_w)); pop_chk(16'(ov_w));
      cr = 1;
      push("mid_rst_q", 16'd0); push("mid_rst_ov", 16'd0);
      tick(); pop_chk(16'(q_w)); pop_chk(16'(ov_w));
      cr = 0;
      push("resume_q", 16'd1);
      tick(); pop_chk(16'(q_w));

      // two-digit decade cascade
      tick();
      cr_c = 0; ep_c = 1;
      for (int i = 1; i <= 100; i++) begin
         push($sformatf("casc_%0d", i), 16'(i % 100));
         tick();
         pop_chk(16'(q_hi) * 16'd10 + 16'(q_lo));
         if (i == 10) begin
            push("casc_lo_ov", 16'd1);
            pop_chk(16'(ov_lo));
         end
         if (i == 99) begin
            push("casc_hi_co99", 16'd1); push("casc_hi_ov99", 16'd0);
            pop_chk(16'(co_hi)); pop_chk(16'(ov_hi));
         end
      end
      push("casc_hi_ov100", 16'd1);
      pop_chk(16'(ov_hi));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
